// File: rtl/sha256_mem_responder_pkg.sv
// Shared types and constants for the SHA-256 engine and its memory responder.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_KICK,
    ST_WAIT_LO,
    ST_WAIT_HI,
    ST_DRAIN
  } resp_state_t;

  localparam int HASH_WORDS         = 8;
  localparam int START_RETRY_CYCLES = 8;

  localparam logic [15:0] DEF_MSG_BASE = 16'h0000;
  localparam logic [15:0] DEF_OUT_BASE = 16'h0080;

endpackage

// File: rtl/sha256_mem_responder_if.sv
// Host load/result streams plus the engine control and memory bus.
// The master side is the host/engine pair, the slave side is the responder.
interface sha256_mem_responder_if;

  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;

  logic        res_valid;
  logic [31:0] res_data;
  logic        res_last;
  logic        res_ready;

  logic        start;
  logic        done;
  logic [15:0] message_addr;
  logic [15:0] output_addr;

  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output load_valid, load_data, res_ready, done, mem_we, mem_addr, mem_write_data,
    input  load_ready, res_valid, res_data, res_last, start, message_addr, output_addr,
           mem_read_data
  );

  modport slave (
    input  load_valid, load_data, res_ready, done, mem_we, mem_addr, mem_write_data,
    output load_ready, res_valid, res_data, res_last, start, message_addr, output_addr,
           mem_read_data
  );

endinterface

// File: rtl/sha256_mem_responder_ram.sv
// Word RAM with one write port and two independent read ports.
// Reads are registered (1-cycle latency) and read-first on a same-address write.
module sha256_dp_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [31:0]   o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [31:0]   o_rdata_b
);

  logic [31:0] r_mem [DEPTH];

  // Write and both reads share one edge so readers see the pre-write word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata_a <= r_mem[i_raddr_a];
    o_rdata_b <= r_mem[i_raddr_b];
  end

endmodule

// File: rtl/sha256_mem_responder.sv
// Memory-side partner of the SHA-256 engine: stores the host message,
// kicks the engine, serves its memory traffic and streams the hash back.
module sha256_mem_responder
  import sha256_pkg::*;
#(
  parameter int          NUM_OF_WORDS = 20,
  parameter int          DEPTH        = 256,
  parameter logic [15:0] MSG_BASE     = DEF_MSG_BASE,
  parameter logic [15:0] OUT_BASE     = DEF_OUT_BASE,
  parameter int          TIMEOUT      = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  sha256_mem_responder_if.slave bus,
  output logic                  o_busy,
  output logic                  o_err_oor,
  output logic                  o_err_proto,
  output logic                  o_err_timeout
);

  localparam int             AW            = $clog2(DEPTH);
  localparam int             WDW           = $clog2(TIMEOUT + 1);
  localparam logic [16:0]    LP_DEPTH      = 17'(DEPTH);
  localparam logic [15:0]    LP_LAST_WORD  = 16'(NUM_OF_WORDS - 1);
  localparam logic [2:0]     LP_LAST_HASH  = 3'(HASH_WORDS - 1);
  localparam logic [2:0]     LP_RETRY_LAST = 3'(START_RETRY_CYCLES - 1);
  localparam logic [WDW-1:0] LP_WDOG_LAST  = WDW'(TIMEOUT - 1);

  resp_state_t    r_state;
  resp_state_t    w_nextState;
  logic [15:0]    r_wcnt;
  logic [WDW-1:0] r_wdog;
  logic [2:0]     r_loCnt;
  logic           r_retried;
  logic [2:0]     r_drainIdx;
  logic           r_resValid;
  logic           r_engRdOk;
  logic           r_errOor;
  logic           r_errProto;
  logic           r_errTimeout;

  logic           w_start;
  logic           w_setTimeout;
  logic           w_hostWe;
  logic           w_engInRange;
  logic           w_engWindow;
  logic           w_engWe;
  logic           w_loMiss;
  logic           w_we;
  logic [AW-1:0]  w_waddr;
  logic [31:0]    w_wdata;
  logic [AW-1:0]  w_hostAddr;
  logic [2:0]     w_drainIdxNext;
  logic [AW-1:0]  w_drainAddr;
  logic [31:0]    w_rdataA;
  logic [31:0]    w_rdataB;

  assign w_hostWe     = (r_state == ST_LOAD) && bus.load_valid;
  assign w_engInRange = ({1'b0, bus.mem_addr} < LP_DEPTH);
  assign w_engWindow  = (r_state == ST_WAIT_LO) || (r_state == ST_WAIT_HI);
  assign w_engWe      = bus.mem_we && w_engInRange && w_engWindow;
  assign w_loMiss     = (r_state == ST_WAIT_LO) && bus.done && (r_loCnt == LP_RETRY_LAST);

  // Host and engine writes live in disjoint states, so a simple mux suffices.
  assign w_hostAddr = AW'(MSG_BASE) + AW'(r_wcnt);
  assign w_we       = w_hostWe || w_engWe;
  assign w_waddr    = w_hostWe ? w_hostAddr : bus.mem_addr[AW-1:0];
  assign w_wdata    = w_hostWe ? bus.load_data : bus.mem_write_data;

  // The drain port looks one word ahead on a handshake so words go out back to back.
  assign w_drainIdxNext = (r_resValid && bus.res_ready) ? r_drainIdx + 3'd1 : r_drainIdx;
  assign w_drainAddr    = AW'(OUT_BASE) + AW'(w_drainIdxNext);

  sha256_dp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (bus.mem_addr[AW-1:0]),
    .o_rdata_a (w_rdataA),
    .i_raddr_b (w_drainAddr),
    .o_rdata_b (w_rdataB)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic, start pulses and watchdog / retry decisions.
  always_comb begin
    w_nextState  = r_state;
    w_start      = 1'b0;
    w_setTimeout = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (w_hostWe && (r_wcnt == LP_LAST_WORD)) begin
          w_nextState = ST_KICK;
        end
      end
      ST_KICK: begin
        w_start     = 1'b1;
        w_nextState = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!bus.done) begin
          w_nextState = ST_WAIT_HI;
        end else if (w_loMiss) begin
          if (r_retried) begin
            w_setTimeout = 1'b1;
            w_nextState  = ST_LOAD;
          end else begin
            w_start = 1'b1;
          end
        end
      end
      ST_WAIT_HI: begin
        if (bus.done) begin
          w_nextState = ST_DRAIN;
        end else if (r_wdog == LP_WDOG_LAST) begin
          w_setTimeout = 1'b1;
          w_nextState  = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (r_resValid && bus.res_ready && (r_drainIdx == LP_LAST_HASH)) begin
          w_nextState = ST_LOAD;
        end
      end
      default: w_nextState = ST_LOAD;
    endcase
  end

  // Message word counter, watchdog (value equals cycles since KICK) and start-retry tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt    <= '0;
      r_wdog    <= '0;
      r_loCnt   <= '0;
      r_retried <= 1'b0;
    end else begin
      if (r_state != ST_LOAD) begin
        r_wcnt <= '0;
      end else if (w_hostWe) begin
        r_wcnt <= r_wcnt + 16'd1;
      end
      if (r_state == ST_KICK) begin
        r_wdog    <= WDW'(1);
        r_loCnt   <= '0;
        r_retried <= 1'b0;
      end else if (w_engWindow) begin
        r_wdog <= r_wdog + WDW'(1);
        if (w_loMiss) begin
          r_loCnt   <= '0;
          r_retried <= 1'b1;
        end else if (r_state == ST_WAIT_LO && bus.done) begin
          r_loCnt <= r_loCnt + 3'd1;
        end
      end
    end
  end

  // Drain sequencer: first word shows one cycle after entry, then advances per handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resValid <= 1'b0;
      r_drainIdx <= '0;
    end else if (r_state == ST_DRAIN) begin
      if (!r_resValid) begin
        r_resValid <= 1'b1;
      end else if (bus.res_ready) begin
        r_drainIdx <= r_drainIdx + 3'd1;
        if (r_drainIdx == LP_LAST_HASH) begin
          r_resValid <= 1'b0;
        end
      end
    end else begin
      r_resValid <= 1'b0;
      r_drainIdx <= '0;
    end
  end

  // Sticky error flags and the out-of-range mask for engine read data.
  // Out-of-range flagging is tied to writes; out-of-range reads just return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_errOor     <= 1'b0;
      r_errProto   <= 1'b0;
      r_errTimeout <= 1'b0;
      r_engRdOk    <= 1'b0;
    end else begin
      if (bus.mem_we && !w_engInRange) begin
        r_errOor <= 1'b1;
      end
      if (bus.mem_we && !w_engWindow) begin
        r_errProto <= 1'b1;
      end
      if (w_setTimeout) begin
        r_errTimeout <= 1'b1;
      end
      r_engRdOk <= w_engInRange;
    end
  end

  assign bus.load_ready    = (r_state == ST_LOAD);
  assign bus.start         = w_start;
  assign bus.message_addr  = MSG_BASE;
  assign bus.output_addr   = OUT_BASE;
  assign bus.mem_read_data = r_engRdOk ? w_rdataA : 32'h0;
  assign bus.res_valid     = r_resValid;
  assign bus.res_data      = r_resValid ? w_rdataB : 32'h0;
  assign bus.res_last      = r_resValid && (r_drainIdx == LP_LAST_HASH);

  assign o_busy        = (r_state != ST_LOAD);
  assign o_err_oor     = r_errOor;
  assign o_err_proto   = r_errProto;
  assign o_err_timeout = r_errTimeout;

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Testbench for sha256_mem_responder: host loader, engine model and result sink
// driven from one sequence, checked against a word-level model of the RAM.
module tb_sha256_mem_responder;
  import sha256_pkg::*;

  localparam int NW  = 20;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic reset;
  logic o_busy;
  logic o_err_oor;
  logic o_err_proto;
  logic o_err_timeout;

  int cmpCount  = 0;
  int failCount = 0;

  logic [31:0] refMem [256];
  logic [31:0] msgBuf [NW];
  logic [31:0] expHash [$];
  bit          readyPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  sha256_mem_responder_if busIf ();

  sha256_mem_responder #(
    .NUM_OF_WORDS (NW),
    .DEPTH        (256),
    .MSG_BASE     (16'h0000),
    .OUT_BASE     (16'h0080),
    .TIMEOUT      (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (busIf),
    .o_busy        (o_busy),
    .o_err_oor     (o_err_oor),
    .o_err_proto   (o_err_proto),
    .o_err_timeout (o_err_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    cmpCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One host word, after a random idle gap.
  task automatic applyStimulus(input logic [31:0] w);
    int gap;
    gap = $urandom_range(0, 2);
    busIf.load_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    busIf.load_valid = 1'b1;
    busIf.load_data  = w;
    checkOutput("load_ready", busIf.load_ready, 1'b1);
    tick();
    busIf.load_valid = 1'b0;
  endtask

  task automatic loadJob();
    for (int i = 0; i < NW; i++) begin
      applyStimulus(msgBuf[i]);
      refMem[i] = msgBuf[i];
    end
    checkOutput("start_kick", busIf.start, 1'b1);
    checkOutput("busy_kick", o_busy, 1'b1);
    checkOutput("load_ready_kick", busIf.load_ready, 1'b0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_start"}, busIf.start, 1'b0);
    checkOutput({tag, "_busy"}, o_busy, 1'b0);
    checkOutput({tag, "_res_valid"}, busIf.res_valid, 1'b0);
    checkOutput({tag, "_res_last"}, busIf.res_last, 1'b0);
    checkOutput({tag, "_res_data"}, busIf.res_data, 32'h0);
    checkOutput({tag, "_mem_rd"}, busIf.mem_read_data, 32'h0);
    checkOutput({tag, "_err_oor"}, o_err_oor, 1'b0);
    checkOutput({tag, "_err_proto"}, o_err_proto, 1'b0);
    checkOutput({tag, "_err_timeout"}, o_err_timeout, 1'b0);
    checkOutput({tag, "_load_ready"}, busIf.load_ready, 1'b1);
  endtask

  // Engine model from start to done, then the drain. readyMode: 0 always, 1 pattern, 2 random.
  task automatic runJob(input int readyMode, input bit directedHash, input bit doRdw);
    logic [31:0] h;
    int          k;
    int          cyc;
    bit          ready;
    expHash.delete();
    tick();
    checkOutput("start_fall", busIf.start, 1'b0);
    busIf.done = 1'b0;
    tick();
    if (doRdw) begin
      busIf.mem_addr = 16'd5;
      tick();
      checkOutput("rd_preload", busIf.mem_read_data, 32'hDEADBEEF);
      busIf.mem_we         = 1'b1;
      busIf.mem_write_data = 32'h1;
      tick();
      busIf.mem_we = 1'b0;
      checkOutput("rd_first", busIf.mem_read_data, 32'hDEADBEEF);
      refMem[5] = 32'h1;
      tick();
      checkOutput("rd_after_wr", busIf.mem_read_data, 32'h1);
      checkOutput("oor_before", o_err_oor, 1'b0);
      busIf.mem_we         = 1'b1;
      busIf.mem_addr       = 16'h0100;
      busIf.mem_write_data = $urandom;
      tick();
      busIf.mem_we = 1'b0;
      checkOutput("oor_set", o_err_oor, 1'b1);
      checkOutput("oor_rd_zero", busIf.mem_read_data, 32'h0);
      busIf.mem_addr = 16'h0000;
      tick();
      checkOutput("oor_no_alias", busIf.mem_read_data, refMem[0]);
      checkOutput("oor_no_proto", o_err_proto, 1'b0);
    end
    for (int a = 0; a < NW; a++) begin
      busIf.mem_addr = 16'(a);
      tick();
      checkOutput("msg_readback", busIf.mem_read_data, refMem[a]);
    end
    for (int j = 0; j < HASH_WORDS; j++) begin
      h = directedHash ? (32'hA0000000 + 32'(j)) : $urandom;
      busIf.mem_we         = 1'b1;
      busIf.mem_addr       = 16'h0080 + 16'(j);
      busIf.mem_write_data = h;
      tick();
      refMem[8'h80 + j] = h;
      expHash.push_back(h);
    end
    busIf.mem_we   = 1'b0;
    busIf.mem_addr = 16'h0000;
    busIf.done     = 1'b1;
    tick();
    checkOutput("drain_first_gap", busIf.res_valid, 1'b0);
    k   = 0;
    cyc = 0;
    while (k < HASH_WORDS && cyc < 64) begin
      case (readyMode)
        0:       ready = 1'b1;
        1:       ready = readyPat[cyc % 4];
        default: ready = 1'($urandom_range(0, 1));
      endcase
      busIf.res_ready = ready;
      if (busIf.res_valid === 1'b1) begin
        checkOutput("res_data", busIf.res_data, expHash[k]);
        checkOutput("res_last", busIf.res_last, 1'(k == HASH_WORDS - 1));
        if (ready) k++;
      end
      tick();
      cyc++;
    end
    busIf.res_ready = 1'b0;
    checkOutput("drain_words", 32'(k), 32'(HASH_WORDS));
    if (readyMode == 0) begin
      // One cycle of RAM latency then one word per cycle.
      checkOutput("drain_cycles", 32'(cyc), 32'(HASH_WORDS + 1));
    end
    checkOutput("drain_done_busy", o_busy, 1'b0);
    checkOutput("drain_done_valid", busIf.res_valid, 1'b0);
  endtask

  initial begin
    int pulses;
    int secondAt;
    int c;

    reset                = 1'b1;
    busIf.load_valid     = 1'b0;
    busIf.load_data      = 32'h0;
    busIf.res_ready      = 1'b0;
    busIf.done           = 1'b1;
    busIf.mem_we         = 1'b0;
    busIf.mem_addr       = 16'h0;
    busIf.mem_write_data = 32'h0;
    tick();
    tick();
    $display("[TB] reset state");
    checkResetValues("rst");
    checkOutput("message_addr", 32'(busIf.message_addr), 32'h0000);
    checkOutput("output_addr", 32'(busIf.output_addr), 32'h0080);
    reset = 1'b0;
    tick();

    $display("[TB] directed job");
    for (int i = 0; i < NW; i++) msgBuf[i] = 32'h01010101 * 32'(i);
    loadJob();
    runJob(0, 1'b1, 1'b0);

    $display("[TB] random job, stalled drain");
    for (int i = 0; i < NW; i++) msgBuf[i] = $urandom;
    loadJob();
    runJob(1, 1'b0, 1'b0);

    $display("[TB] random job, read-during-write and out-of-range");
    for (int i = 0; i < NW; i++) msgBuf[i] = $urandom;
    msgBuf[5] = 32'hDEADBEEF;
    loadJob();
    runJob(2, 1'b0, 1'b1);

    $display("[TB] engine write during LOAD");
    checkOutput("proto_before", o_err_proto, 1'b0);
    busIf.mem_we         = 1'b1;
    busIf.mem_addr       = 16'h0010;
    busIf.mem_write_data = ~refMem[16];
    tick();
    busIf.mem_we = 1'b0;
    tick();
    checkOutput("proto_set", o_err_proto, 1'b1);
    checkOutput("proto_dropped", busIf.mem_read_data, refMem[16]);
    checkOutput("oor_sticky", o_err_oor, 1'b1);
    busIf.mem_addr = 16'h0000;

    $display("[TB] done never falls");
    for (int i = 0; i < NW; i++) msgBuf[i] = $urandom;
    checkOutput("tmo_lo_before", o_err_timeout, 1'b0);
    loadJob();
    pulses   = 1;
    secondAt = -1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (busIf.start === 1'b1) begin
        pulses++;
        if (pulses == 2) secondAt = t;
      end
    end
    checkOutput("retry_pulses", 32'(pulses), 32'd2);
    checkOutput("retry_gap", 32'(secondAt), 32'd8);
    checkOutput("tmo_lo_set", o_err_timeout, 1'b1);
    checkOutput("tmo_lo_load", o_busy, 1'b0);

    $display("[TB] reset mid-load");
    for (int i = 0; i < 10; i++) begin
      msgBuf[i] = $urandom;
      applyStimulus(msgBuf[i]);
      refMem[i] = msgBuf[i];
    end
    checkOutput("partial_load_busy", o_busy, 1'b0);
    reset = 1'b1;
    tick();
    checkResetValues("midrst");
    reset = 1'b0;
    tick();
    for (int i = 0; i < NW; i++) msgBuf[i] = $urandom;
    loadJob();
    runJob(2, 1'b0, 1'b0);

    $display("[TB] done falls but never rises");
    for (int i = 0; i < NW; i++) msgBuf[i] = $urandom;
    checkOutput("tmo_hi_before", o_err_timeout, 1'b0);
    loadJob();
    c = 0;
    tick();
    c++;
    busIf.done = 1'b0;
    while (o_err_timeout !== 1'b1 && c < 1100) begin
      tick();
      c++;
    end
    checkOutput("tmo_hi_cycles", 32'(c), 32'(TMO));
    checkOutput("tmo_hi_load", o_busy, 1'b0);
    busIf.done = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
